// File: rtl/stp_coeff_writer.sv
// rtl/stp_coeff_writer.sv - store-polynomial writer: copies N+1 coefficients into S slot A, then records N
module stp_coeff_writer #(
    parameter int BUFFER_SIZE = 1024,
    parameter int MAX_DEGREE  = 10,
    parameter int AW          = $clog2(BUFFER_SIZE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start_stp,
    input  logic [2:0]    i_A,
    input  logic [4:0]    i_N,
    input  logic [AW-1:0] i_rd_addr_data,
    input  logic [15:0]   i_data_in,
    output logic          o_en_rd_data,
    output logic [AW-1:0] o_rd_addr_data_updated,
    output logic          o_en_wr_S,
    output logic [6:0]    o_wr_addr_S,
    output logic [15:0]   o_wr_data_S,
    output logic          o_en_wr_N,
    output logic [2:0]    o_wr_addr_N,
    output logic [4:0]    o_wr_data_N,
    output logic          o_done_stp,
    output logic [31:0]   o_status
);

    localparam int IW = $clog2(MAX_DEGREE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK_N, S_RD_COEFF, S_WR_COEFF, S_WR_N, S_ERROR, S_END
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_a;
    logic [4:0]      r_n;
    logic [IW-1:0]   r_i;
    logic [AW-1:0]   r_ptr;
    logic [31:0]     r_status;
    logic            w_last;
    logic            w_bad;
    logic            w_wr_s;
    logic [6:0]      w_slot_base;

    assign w_last      = (5'(r_i) == r_n);
    assign w_bad       = (r_n > 5'(MAX_DEGREE));
    assign w_slot_base = 7'(r_a) * 7'(MAX_DEGREE + 1);
    assign w_wr_s      = (r_state == S_WR_COEFF);

    // State register; reset aborts any operation immediately
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start_stp) w_next = S_CHECK_N;
            S_CHECK_N:  w_next = w_bad ? S_ERROR : S_RD_COEFF;
            S_RD_COEFF: w_next = S_WR_COEFF;
            S_WR_COEFF: w_next = w_last ? S_WR_N : S_RD_COEFF;
            S_WR_N:     w_next = S_END;
            S_ERROR:    w_next = S_END;
            S_END:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Operand latch, coefficient index, buffer pointer and status
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_a      <= '0;
            r_n      <= '0;
            r_i      <= '0;
            r_ptr    <= '0;
            r_status <= 32'hFFFF_FFFF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start_stp) begin
                        r_a      <= i_A;
                        r_n      <= i_N;
                        r_i      <= '0;
                        r_ptr    <= i_rd_addr_data;
                        r_status <= 32'hFFFF_FFFF;
                    end
                end
                S_RD_COEFF: begin
                    r_ptr <= (r_ptr == AW'(BUFFER_SIZE - 1)) ? '0 : r_ptr + 1'b1;
                end
                S_WR_COEFF: begin
                    if (!w_last) r_i <= r_i + 1'b1;
                end
                S_WR_N:  r_status <= 32'd0;
                S_ERROR: r_status <= 32'd2;
                default: ;
            endcase
        end
    end

    assign o_en_rd_data           = (r_state == S_RD_COEFF);
    assign o_rd_addr_data_updated = r_ptr;
    assign o_en_wr_S              = w_wr_s;
    assign o_wr_addr_S            = w_slot_base + 7'(r_i);
    assign o_wr_data_S            = w_wr_s ? i_data_in : 16'd0;
    assign o_en_wr_N              = (r_state == S_WR_N);
    assign o_wr_addr_N            = r_a;
    assign o_wr_data_N            = r_n;
    assign o_done_stp             = (r_state == S_END);
    assign o_status               = r_status;

endmodule
